// File: rtl/audio_clk_nco_if.sv
// Control and clock-output bundle of the audio clock NCO.
// The controller drives run/config requests; the NCO returns the audio clocks and strobes.
interface audio_clk_nco_if #(
  parameter int ACC_W = 32
);
  logic             enable;
  logic [ACC_W-1:0] cfg_fw;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             mclk;
  logic             bclk;
  logic             lrck;
  logic             bclk_fall;
  logic             frame_start;
  logic             running;

  modport master (
    output enable, cfg_fw, cfg_valid,
    input  cfg_ready, mclk, bclk, lrck, bclk_fall, frame_start, running
  );

  modport slave (
    input  enable, cfg_fw, cfg_valid,
    output cfg_ready, mclk, bclk, lrck, bclk_fall, frame_start, running
  );
endinterface

// File: rtl/audio_clk_nco.sv
// Phase-accumulator audio clock generator: derives MCLK/BCLK/LRCK plus clk-domain
// strobes from the fabric clock, with frame-aligned frequency-word updates.
module audio_clk_nco #(
  parameter int             ACC_W    = 32,
  parameter int             MCLK_FS  = 256,
  parameter int             BCLK_FS  = 64,
  parameter logic [ACC_W-1:0] FW_RESET = 32'h3EEA209A
) (
  input  logic            clk,
  input  logic            rst_n,
  audio_clk_nco_if.slave  bus
);

  localparam int CNT_W = $clog2(MCLK_FS);
  localparam int RATIO = MCLK_FS / BCLK_FS;
  localparam int BSEL  = $clog2(RATIO) - 1;
  localparam logic [ACC_W-1:0] FW_MAX = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [ACC_W-1:0]   fw, fw_nxt;
  logic [ACC_W-1:0]   pend_fw, pend_fw_nxt;
  logic               pend_valid, pend_valid_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               mclk, mclk_nxt;
  logic               bclk, bclk_nxt;
  logic               lrck, lrck_nxt;
  logic               bclk_fall, bclk_fall_nxt;
  logic               frame_start, frame_start_nxt;
  logic               running, running_nxt;

  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   fw_clamped;
  logic               active;
  logic               tick;
  logic               mclk_fall;
  logic               wrap;
  logic               take;
  logic               apply;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      fw          <= FW_RESET;
      pend_fw     <= '0;
      pend_valid  <= 1'b0;
      cnt         <= '0;
      mclk        <= 1'b0;
      bclk        <= 1'b0;
      lrck        <= 1'b0;
      bclk_fall   <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      fw          <= fw_nxt;
      pend_fw     <= pend_fw_nxt;
      pend_valid  <= pend_valid_nxt;
      cnt         <= cnt_nxt;
      mclk        <= mclk_nxt;
      bclk        <= bclk_nxt;
      lrck        <= lrck_nxt;
      bclk_fall   <= bclk_fall_nxt;
      frame_start <= frame_start_nxt;
      running     <= running_nxt;
    end
  end

  always_comb begin
    sum        = {1'b0, acc} + {1'b0, fw};
    fw_clamped = bus.cfg_fw[ACC_W-1] ? FW_MAX : bus.cfg_fw;
    active     = (state != IDLE);
    tick       = active && sum[ACC_W];
    mclk_fall  = tick && mclk;
    wrap       = mclk_fall && (cnt == '1);

    state_nxt = state;
    case (state)
      IDLE:    if (bus.enable) state_nxt = RUN;
      RUN:     if (!bus.enable) state_nxt = DRAIN;
      // Re-enable wins over the final wrap so an uninterrupted clock keeps running.
      DRAIN: begin
        if (bus.enable)  state_nxt = RUN;
        else if (wrap)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    acc_nxt  = active ? sum[ACC_W-1:0] : '0;
    mclk_nxt = tick ? ~mclk : mclk;
    cnt_nxt  = mclk_fall ? cnt + 1'b1 : cnt;
    if (state_nxt == IDLE) begin
      acc_nxt  = '0;
      mclk_nxt = 1'b0;
      cnt_nxt  = '0;
    end

    bclk_nxt      = cnt_nxt[BSEL];
    lrck_nxt      = cnt_nxt[CNT_W-1];
    bclk_fall_nxt = bclk && !bclk_nxt;
    frame_start_nxt = ((state == IDLE) && bus.enable) ||
                      (wrap && (state_nxt == RUN));
    running_nxt   = (state_nxt != IDLE);

    // One-deep pending slot; a full slot blocks new words rather than overwriting.
    take           = bus.cfg_valid && !pend_valid;
    apply          = pend_valid && ((state == IDLE) || wrap);
    fw_nxt         = apply ? pend_fw : fw;
    pend_fw_nxt    = take ? fw_clamped : pend_fw;
    pend_valid_nxt = pend_valid;
    if (apply)     pend_valid_nxt = 1'b0;
    else if (take) pend_valid_nxt = 1'b1;
  end

  assign bus.cfg_ready   = ~pend_valid;
  assign bus.mclk        = mclk;
  assign bus.bclk        = bclk;
  assign bus.lrck        = lrck;
  assign bus.bclk_fall   = bclk_fall;
  assign bus.frame_start = frame_start;
  assign bus.running     = running;

endmodule

// File: tb/tb_audio_clk_nco.sv
// Directed bench for audio_clk_nco with ACC_W=8, MCLK_FS=8, BCLK_FS=4, fw=8'h40.
module tb_audio_clk_nco;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  audio_clk_nco_if #(.ACC_W(8)) bus ();

  audio_clk_nco #(
    .ACC_W   (8),
    .MCLK_FS (8),
    .BCLK_FS (4),
    .FW_RESET(8'h40)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mclk, bclk, lrck, bclk_fall, frame_start, running, cfg_ready}
  logic [6:0] obs;
  assign obs = {bus.mclk, bus.bclk, bus.lrck, bus.bclk_fall, bus.frame_start,
                bus.running, bus.cfg_ready};

  // Ideal phase-aligned pattern k cycles after the start of a run, one tick every 2^p clk.
  function automatic logic [4:0] ideal(input int k, input int p);
    logic [4:0] r;
    r[4] = ((k >> p) & 1) != 0;
    r[3] = ((k >> (p + 1)) & 1) != 0;
    r[2] = ((k >> (p + 3)) & 1) != 0;
    r[1] = (k != 0) && ((k % (1 << (p + 2))) == 0);
    r[0] = (k % (1 << (p + 4))) == 0;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.enable    = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_fw    = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== 7'b0000001) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b", obs, 7'b0000001);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++;
    if (obs !== 7'b0000001) begin
      bad++;
      $display("FAIL idle_after_reset got=%b exp=%b", obs, 7'b0000001);
    end
  endtask

  task automatic test_basic_run();
    logic [6:0] exp;
    bus.enable = 1'b1;
    for (int k = 0; k < 128; k++) begin
      step();
      exp = {ideal(k, 2), 1'b1, 1'b1};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL basic_run k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
  endtask

  task automatic test_drain();
    logic [6:0] exp;
    for (int k = 128; k <= 200; k++) begin
      step();
      if (k <= 191)      exp = {ideal(k, 2), 1'b1, 1'b1};
      else if (k == 192) exp = 7'b0001001;
      else               exp = 7'b0000001;
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL drain k=%0d got=%b exp=%b", k, obs, exp);
      end
      if (k == 152) bus.enable = 1'b0;
    end
  endtask

  task automatic test_reenable_drain();
    logic [6:0] exp;
    bus.enable = 1'b1;
    for (int j = 0; j <= 80; j++) begin
      step();
      exp = {ideal(j, 2), 1'b1, 1'b1};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL reenable j=%0d got=%b exp=%b", j, obs, exp);
      end
      if (j == 20) bus.enable = 1'b0;
      if (j == 30) bus.enable = 1'b1;
    end
  endtask

  task automatic test_live_reconfig();
    logic [6:0] exp;
    logic       rdy;
    for (int j = 81; j <= 168; j++) begin
      step();
      rdy = !(j >= 85 && j <= 127);
      exp = (j <= 128) ? {ideal(j, 2), 1'b1, rdy} : {ideal(j - 128, 3), 1'b1, rdy};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL live_reconfig j=%0d got=%b exp=%b", j, obs, exp);
      end
      if (j == 84)  begin bus.cfg_valid = 1'b1; bus.cfg_fw = 8'h20; end
      if (j == 85)  bus.cfg_valid = 1'b0;
      if (j == 100) begin bus.cfg_valid = 1'b1; bus.cfg_fw = 8'h80; end
      if (j == 101) bus.cfg_valid = 1'b0;
    end
  endtask

  task automatic test_clamp();
    logic [6:0] exp;
    logic       rdy;
    for (int m = 41; m <= 168; m++) begin
      step();
      rdy = !(m >= 42 && m <= 127);
      exp = (m <= 128) ? {ideal(m, 3), 1'b1, rdy} : {ideal(m - 128, 1), 1'b1, rdy};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL clamp m=%0d got=%b exp=%b", m, obs, exp);
      end
      if (m == 41) begin bus.cfg_valid = 1'b1; bus.cfg_fw = 8'hF0; end
      if (m == 42) bus.cfg_valid = 1'b0;
    end
  endtask

  task automatic test_zero_freeze();
    logic [6:0] exp;
    logic       rdy;
    for (int n = 41; n <= 100; n++) begin
      step();
      rdy = !((n >= 42 && n <= 63) || n >= 67);
      exp = (n <= 64) ? {ideal(n, 1), 1'b1, rdy} : {5'b00000, 1'b1, rdy};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL zero_freeze n=%0d got=%b exp=%b", n, obs, exp);
      end
      if (n == 41) begin bus.cfg_valid = 1'b1; bus.cfg_fw = 8'h00; end
      if (n == 42) bus.cfg_valid = 1'b0;
      if (n == 66) begin bus.cfg_valid = 1'b1; bus.cfg_fw = 8'h20; end
      if (n == 67) bus.cfg_valid = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] exp;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 7'b0000001) begin
      bad++;
      $display("FAIL async_reset_frozen got=%b exp=%b", obs, 7'b0000001);
    end
    bus.enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++;
    if (obs !== 7'b0000001) begin
      bad++;
      $display("FAIL idle_after_release got=%b exp=%b", obs, 7'b0000001);
    end

    bus.enable = 1'b1;
    for (int k = 0; k <= 13; k++) begin
      step();
      exp = {ideal(k, 2), 1'b1, !(k >= 11)};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL pre_reset_run k=%0d got=%b exp=%b", k, obs, exp);
      end
      if (k == 10) begin bus.cfg_valid = 1'b1; bus.cfg_fw = 8'h20; end
      if (k == 11) bus.cfg_valid = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 7'b0000001) begin
      bad++;
      $display("FAIL async_reset_midframe got=%b exp=%b", obs, 7'b0000001);
    end

    bus.enable = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    bus.enable = 1'b1;
    for (int k = 0; k <= 70; k++) begin
      step();
      exp = {ideal(k, 2), 1'b1, 1'b1};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL post_reset_run k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_drain();
    test_reenable_drain();
    test_live_reconfig();
    test_clamp();
    test_zero_freeze();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
